lpif_link_online_seq: RTL and testbench
=======================================

Name: lpif_link_online_seq

Overview:
- Link bring-up sequencer for the LPIF logic-link datapath. It generates the tx_online and rx_online controls consumed by the auto-sync and concat blocks.
- Brings the link up in order: waits for PHY alignment, waits a settle time, goes tx-online, then waits for the remote marker before going rx-online.
- Retries on marker timeout, drops the link on alignment loss, and enters a sticky error state after too many retries.

Parameters:
- MAX_RETRY, 3, marker-timeout retries allowed before ERROR (1..15).
- TIMER_W, 16, width of the settle/timeout counter and of the delay inputs.

Ports:
- clk_wr  in  1  single clock.
- rst_wr_n  in  1  asynchronous active-low reset.
- link_en  in  1  level; enables bring-up; low forces IDLE.
- phy_align_done  in  1  level from PHY; all lanes aligned.
- rx_marker_seen  in  1  pulse or level; remote marker detected.
- delay_x_value  in  TIMER_W  settle cycles between alignment and tx_online.
- delay_y_value  in  TIMER_W  marker timeout cycles; 0 disables the timeout.
- tx_online  out  1  to auto-sync tx_online.
- rx_online  out  1  to auto-sync rx_online.
- link_up  out  1  high in UP.
- link_err  out  1  high in ERROR.
- seq_state  out  3  current state encoding, for debug status.
- retry_cnt  out  4  marker-timeout retries in the current attempt.
- loss_cnt  out  8  alignment-loss count; see Optional Feature.

Behaviour:
- Clock and reset: one clock, clk_wr. Reset rst_wr_n is asynchronous, active-low.
- Reset values: state=IDLE, timer=0, retry_cnt=0, loss_cnt=0. All outputs 0.
- Outputs are decoded from the registered state only. No combinational path exists from inputs to outputs.
- State encoding: IDLE=0, WAIT_ALIGN=1, SETTLE=2, TX_ON=3, UP=4, ERROR=5.
- Output decode:
  - tx_online=1 in TX_ON and UP.
  - rx_online=1 in UP only.
  - link_up=1 in UP.
  - link_err=1 in ERROR.
- Global rule, highest priority: link_en=0 moves the next state to IDLE from any state. retry_cnt clears; loss_cnt is kept.
- IDLE:
  - link_en=1 -> WAIT_ALIGN.
  - retry_cnt cleared.
- WAIT_ALIGN:
  - phy_align_done=1 -> SETTLE.
  - timer loads delay_x_value on that transition.
- SETTLE:
  - phy_align_done=0 -> WAIT_ALIGN.
  - Otherwise, timer==0 -> TX_ON, and timer loads delay_y_value.
  - Otherwise timer decrements.
  - Result: SETTLE lasts delay_x_value+1 cycles. delay_x_value=0 gives 1 cycle.
- TX_ON, evaluated in priority order:
  - phy_align_done=0 -> WAIT_ALIGN. Not counted as a retry.
  - rx_marker_seen=1 -> UP. Marker wins over a timeout in the same cycle.
  - delay_y_value!=0 and timer==1 -> timeout. Otherwise timer decrements, saturating at 0.
- Timeout handling:
  - If retry_cnt==MAX_RETRY-1 -> ERROR, and retry_cnt becomes MAX_RETRY.
  - Else retry_cnt+1 -> WAIT_ALIGN.
  - tx_online drops in the cycle the state leaves TX_ON.
- delay_y_value sampling: the value is sampled only at TX_ON entry. Changes mid-wait are ignored.
- UP:
  - phy_align_done=0 -> WAIT_ALIGN, loss_cnt increments.
  - rx_marker_seen is ignored in UP.
- ERROR: sticky. Exits only via link_en=0 -> IDLE.
- Reset asserted mid-sequence: immediate return to reset values, asynchronously.
- Latency: tx_online rises delay_x_value+2 cycles after phy_align_done rises while in WAIT_ALIGN. rx_online rises 1 cycle after rx_marker_seen is sampled in TX_ON.

Optional Feature:
- Macro: LPIF_SEQ_LOSS_CNT_EN.
- Defined:
  - loss_cnt is an 8-bit counter incremented on every UP->WAIT_ALIGN transition.
  - It saturates at 255.
  - It clears only on reset.
- Undefined: loss_cnt is tied to 0 and no counter flops are inferred. The port always exists.

Decomposition:
- Package lpif_seq_pkg holds:
  - the state enum typedef (3-bit, values as above);
  - constants SEQ_TIMER_W=16 and SEQ_LOSS_W=8.
- Sub-module lpif_seq_timer: TIMER_W down-counter with load value, load strobe, decrement enable, and zero/one flags. It is used for both the settle and timeout phases.

Test Plan:
1. Happy path:
   - Stimulus: reset, then link_en=1, phy_align_done=1 at cycle 10, delay_x_value=5, delay_y_value=100, rx_marker_seen pulse at cycle 40.
   - Response: tx_online rises at cycle 17, rx_online and link_up rise at cycle 41, seq_state=4.
2. Retry to ERROR:
   - Stimulus: MAX_RETRY=3, delay_x_value=0, delay_y_value=4, no marker.
   - Response: three timeouts, retry_cnt steps 1, 2, then 3 with link_err=1, tx_online=0.
   - Then link_en=0 -> IDLE and retry_cnt=0.
3. Marker/timeout collision:
   - Stimulus: rx_marker_seen asserted in the same cycle timer==1.
   - Response: UP entered, retry_cnt unchanged.
4. Alignment loss:
   - Stimulus: in UP, drop phy_align_done for 1 cycle.
   - Response: tx_online and rx_online go to 0 the next cycle. With LPIF_SEQ_LOSS_CNT_EN, loss_cnt=1; without it, 0. Link then re-sequences to UP.
5. delay_y_value=0:
   - Stimulus: no marker for 10000 cycles.
   - Response: stays in TX_ON, retry_cnt=0.
6. Reset mid-SETTLE:
   - Stimulus: delay_x_value=1000, assert rst_wr_n=0 at cycle 200 of SETTLE.
   - Response: state and all outputs return to 0 immediately, without a clock edge.

Source files
------------

// File: rtl/lpif_seq_pkg.sv
// rtl/lpif_seq_pkg.sv - shared state encoding and widths for the LPIF link bring-up sequencer
package lpif_seq_pkg;

    localparam int SEQ_TIMER_W = 16;
    localparam int SEQ_LOSS_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_ALIGN = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_TX_ON      = 3'd3,
        ST_UP         = 3'd4,
        ST_ERROR      = 3'd5
    } seq_state_e;

endpackage

// File: rtl/lpif_seq_timer.sv
// rtl/lpif_seq_timer.sv - loadable saturating down-counter shared by the settle and marker-timeout phases
import lpif_seq_pkg::*;

module lpif_seq_timer #(
    parameter int TIMER_W = SEQ_TIMER_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    input  logic               i_dec,
    output logic               o_zero,
    output logic               o_one
);

    logic [TIMER_W-1:0] r_cnt;

    // Load has priority over decrement; decrement stops at zero so a zero load never reaches one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);
    assign o_one  = (r_cnt == TIMER_W'(1));

endmodule

// File: rtl/lpif_link_online_seq.sv
// rtl/lpif_link_online_seq.sv - LPIF link bring-up sequencer driving tx_online/rx_online (optional LPIF_SEQ_LOSS_CNT_EN)
import lpif_seq_pkg::*;

module lpif_link_online_seq #(
    parameter int MAX_RETRY = 3,
    parameter int TIMER_W   = SEQ_TIMER_W
) (
    input  logic                  clk_wr,
    input  logic                  rst_wr_n,
    input  logic                  link_en,
    input  logic                  phy_align_done,
    input  logic                  rx_marker_seen,
    input  logic [TIMER_W-1:0]    delay_x_value,
    input  logic [TIMER_W-1:0]    delay_y_value,
    output logic                  tx_online,
    output logic                  rx_online,
    output logic                  link_up,
    output logic                  link_err,
    output logic [2:0]            seq_state,
    output logic [3:0]            retry_cnt,
    output logic [SEQ_LOSS_W-1:0] loss_cnt
);

    seq_state_e         r_state;
    seq_state_e         w_state_nxt;
    logic [3:0]         r_retry;
    logic [3:0]         w_retry_nxt;
    logic               w_tmr_load;
    logic [TIMER_W-1:0] w_tmr_load_val;
    logic               w_tmr_dec;
    logic               w_tmr_zero;
    logic               w_tmr_one;

    lpif_seq_timer #(.TIMER_W(TIMER_W)) u_timer (
        .i_clk      (clk_wr),
        .i_rst_n    (rst_wr_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_load_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero),
        .o_one      (w_tmr_one)
    );

    // State and retry counter registers.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            r_state <= ST_IDLE;
            r_retry <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_retry <= w_retry_nxt;
        end
    end

    // Next-state, retry and timer control; link_en low overrides every state.
    // The timeout uses timer==1 only: a zero delay_y_value loads zero, which never reaches one,
    // so the timeout is disabled and mid-wait changes of delay_y_value have no effect.
    always_comb begin
        w_state_nxt    = r_state;
        w_retry_nxt    = r_retry;
        w_tmr_load     = 1'b0;
        w_tmr_load_val = delay_x_value;
        w_tmr_dec      = 1'b0;
        if (!link_en) begin
            w_state_nxt = ST_IDLE;
            w_retry_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_retry_nxt = '0;
                    w_state_nxt = ST_WAIT_ALIGN;
                end
                ST_WAIT_ALIGN: begin
                    if (phy_align_done) begin
                        w_state_nxt    = ST_SETTLE;
                        w_tmr_load     = 1'b1;
                        w_tmr_load_val = delay_x_value;
                    end
                end
                ST_SETTLE: begin
                    if (!phy_align_done) begin
                        w_state_nxt = ST_WAIT_ALIGN;
                    end else if (w_tmr_zero) begin
                        w_state_nxt    = ST_TX_ON;
                        w_tmr_load     = 1'b1;
                        w_tmr_load_val = delay_y_value;
                    end else begin
                        w_tmr_dec = 1'b1;
                    end
                end
                ST_TX_ON: begin
                    if (!phy_align_done) begin
                        w_state_nxt = ST_WAIT_ALIGN;
                    end else if (rx_marker_seen) begin
                        w_state_nxt = ST_UP;
                    end else if (w_tmr_one) begin
                        if (r_retry == 4'(MAX_RETRY - 1)) begin
                            w_state_nxt = ST_ERROR;
                            w_retry_nxt = 4'(MAX_RETRY);
                        end else begin
                            w_state_nxt = ST_WAIT_ALIGN;
                            w_retry_nxt = r_retry + 4'd1;
                        end
                    end else begin
                        w_tmr_dec = 1'b1;
                    end
                end
                ST_UP: begin
                    if (!phy_align_done) begin
                        w_state_nxt = ST_WAIT_ALIGN;
                    end
                end
                ST_ERROR: begin
                    w_state_nxt = ST_ERROR;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

`ifdef LPIF_SEQ_LOSS_CNT_EN
    logic [SEQ_LOSS_W-1:0] r_loss_cnt;
    logic                  w_loss_inc;

    assign w_loss_inc = (r_state == ST_UP) && link_en && !phy_align_done;

    // Saturating alignment-loss counter; survives link_en toggles, cleared only by reset.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            r_loss_cnt <= '0;
        end else if (w_loss_inc && (r_loss_cnt != {SEQ_LOSS_W{1'b1}})) begin
            r_loss_cnt <= r_loss_cnt + 1'b1;
        end
    end

    assign loss_cnt = r_loss_cnt;
`else
    assign loss_cnt = '0;
`endif

    assign tx_online = (r_state == ST_TX_ON) || (r_state == ST_UP);
    assign rx_online = (r_state == ST_UP);
    assign link_up   = (r_state == ST_UP);
    assign link_err  = (r_state == ST_ERROR);
    assign seq_state = r_state;
    assign retry_cnt = r_retry;

endmodule

// File: tb/tb_lpif_link_online_seq.sv
// tb/tb_lpif_link_online_seq.sv - directed self-checking bench for lpif_link_online_seq
module tb_lpif_link_online_seq;

    logic        clk_wr;
    logic        rst_wr_n;
    logic        link_en;
    logic        phy_align_done;
    logic        rx_marker_seen;
    logic [15:0] delay_x_value;
    logic [15:0] delay_y_value;
    logic        tx_online;
    logic        rx_online;
    logic        link_up;
    logic        link_err;
    logic [2:0]  seq_state;
    logic [3:0]  retry_cnt;
    logic [7:0]  loss_cnt;

    int n_pass;
    int n_total;

`ifdef LPIF_SEQ_LOSS_CNT_EN
    localparam logic [7:0] EXP_LOSS = 8'd1;
`else
    localparam logic [7:0] EXP_LOSS = 8'd0;
`endif

    lpif_link_online_seq #(.MAX_RETRY(3), .TIMER_W(16)) dut (
        .clk_wr         (clk_wr),
        .rst_wr_n       (rst_wr_n),
        .link_en        (link_en),
        .phy_align_done (phy_align_done),
        .rx_marker_seen (rx_marker_seen),
        .delay_x_value  (delay_x_value),
        .delay_y_value  (delay_y_value),
        .tx_online      (tx_online),
        .rx_online      (rx_online),
        .link_up        (link_up),
        .link_err       (link_err),
        .seq_state      (seq_state),
        .retry_cnt      (retry_cnt),
        .loss_cnt       (loss_cnt)
    );

    initial clk_wr = 1'b0;
    always #5 clk_wr = ~clk_wr;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_wr);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_wr_n = 1'b0; link_en = 1'b0; phy_align_done = 1'b0; rx_marker_seen = 1'b0;
        delay_x_value = 16'd0; delay_y_value = 16'd0;
        tick(3);
        n_total++;
        if ({seq_state, tx_online, rx_online, link_up, link_err, retry_cnt, loss_cnt} !== 19'd0)
            $display("FAIL reset_outputs: got state=%0d tx=%b rx=%b up=%b err=%b retry=%0d loss=%0d, want all 0",
                     seq_state, tx_online, rx_online, link_up, link_err, retry_cnt, loss_cnt);
        else n_pass++;
        rst_wr_n = 1'b1;
        tick(2);
        n_total++;
        if (seq_state !== 3'd0) $display("FAIL reset_idle_hold: state=%0d want 0", seq_state);
        else n_pass++;
    endtask

    task automatic test_happy_path();
        link_en = 1'b1;
        tick(9);
        n_total++;
        if (seq_state !== 3'd1) $display("FAIL happy_wait_align: state=%0d want 1", seq_state);
        else n_pass++;
        delay_x_value = 16'd5; delay_y_value = 16'd100; phy_align_done = 1'b1;
        tick(6);
        n_total++;
        if (tx_online !== 1'b0 || seq_state !== 3'd2)
            $display("FAIL happy_tx_early: tx=%b state=%0d want tx=0 state=2", tx_online, seq_state);
        else n_pass++;
        tick(1);
        n_total++;
        if (tx_online !== 1'b1 || rx_online !== 1'b0 || seq_state !== 3'd3)
            $display("FAIL happy_tx_on: tx=%b rx=%b state=%0d want tx=1 rx=0 state=3", tx_online, rx_online, seq_state);
        else n_pass++;
        tick(23);
        n_total++;
        if (seq_state !== 3'd3 || rx_online !== 1'b0)
            $display("FAIL happy_hold_tx: state=%0d rx=%b want state=3 rx=0", seq_state, rx_online);
        else n_pass++;
        rx_marker_seen = 1'b1;
        tick(1);
        rx_marker_seen = 1'b0;
        n_total++;
        if (rx_online !== 1'b1 || link_up !== 1'b1 || tx_online !== 1'b1 || seq_state !== 3'd4)
            $display("FAIL happy_up: rx=%b up=%b tx=%b state=%0d want 1 1 1 4", rx_online, link_up, tx_online, seq_state);
        else n_pass++;
        rx_marker_seen = 1'b1;
        tick(2);
        rx_marker_seen = 1'b0;
        n_total++;
        if (seq_state !== 3'd4) $display("FAIL happy_marker_ignored: state=%0d want 4", seq_state);
        else n_pass++;
    endtask

    task automatic test_retry_error();
        link_en = 1'b0;
        tick(1);
        delay_x_value = 16'd0; delay_y_value = 16'd4; phy_align_done = 1'b1; link_en = 1'b1;
        tick(3);
        n_total++;
        if (seq_state !== 3'd3 || tx_online !== 1'b1)
            $display("FAIL retry_first_tx: state=%0d tx=%b want 3 1", seq_state, tx_online);
        else n_pass++;
        for (int r = 1; r <= 3; r++) begin
            tick(3);
            n_total++;
            if (tx_online !== 1'b1 || retry_cnt !== 4'(r - 1))
                $display("FAIL retry_pre_timeout_%0d: tx=%b retry=%0d want tx=1 retry=%0d", r, tx_online, retry_cnt, r - 1);
            else n_pass++;
            tick(1);
            n_total++;
            if (r < 3) begin
                if (retry_cnt !== 4'(r) || seq_state !== 3'd1 || tx_online !== 1'b0 || link_err !== 1'b0)
                    $display("FAIL retry_step_%0d: retry=%0d state=%0d tx=%b err=%b want %0d 1 0 0",
                             r, retry_cnt, seq_state, tx_online, link_err, r);
                else n_pass++;
                tick(2);
            end else begin
                if (retry_cnt !== 4'd3 || seq_state !== 3'd5 || tx_online !== 1'b0 || link_err !== 1'b1)
                    $display("FAIL retry_error: retry=%0d state=%0d tx=%b err=%b want 3 5 0 1",
                             retry_cnt, seq_state, tx_online, link_err);
                else n_pass++;
            end
        end
        rx_marker_seen = 1'b1;
        tick(5);
        rx_marker_seen = 1'b0;
        n_total++;
        if (seq_state !== 3'd5 || link_err !== 1'b1)
            $display("FAIL error_sticky: state=%0d err=%b want 5 1", seq_state, link_err);
        else n_pass++;
        link_en = 1'b0;
        tick(1);
        n_total++;
        if (seq_state !== 3'd0 || retry_cnt !== 4'd0 || link_err !== 1'b0)
            $display("FAIL error_exit: state=%0d retry=%0d err=%b want 0 0 0", seq_state, retry_cnt, link_err);
        else n_pass++;
    endtask

    task automatic test_collision();
        delay_x_value = 16'd0; delay_y_value = 16'd4; phy_align_done = 1'b1; link_en = 1'b1;
        tick(3);
        tick(4);
        n_total++;
        if (retry_cnt !== 4'd1 || seq_state !== 3'd1)
            $display("FAIL collide_setup: retry=%0d state=%0d want 1 1", retry_cnt, seq_state);
        else n_pass++;
        tick(2);
        tick(3);
        rx_marker_seen = 1'b1;
        tick(1);
        rx_marker_seen = 1'b0;
        n_total++;
        if (seq_state !== 3'd4 || retry_cnt !== 4'd1 || link_up !== 1'b1)
            $display("FAIL collide_marker_wins: state=%0d retry=%0d up=%b want 4 1 1", seq_state, retry_cnt, link_up);
        else n_pass++;
    endtask

    task automatic test_align_loss();
        phy_align_done = 1'b0;
        tick(1);
        phy_align_done = 1'b1;
        n_total++;
        if (seq_state !== 3'd1 || tx_online !== 1'b0 || rx_online !== 1'b0 || loss_cnt !== EXP_LOSS)
            $display("FAIL loss_drop: state=%0d tx=%b rx=%b loss=%0d want 1 0 0 %0d",
                     seq_state, tx_online, rx_online, loss_cnt, EXP_LOSS);
        else n_pass++;
        tick(2);
        n_total++;
        if (seq_state !== 3'd3 || tx_online !== 1'b1)
            $display("FAIL loss_retx: state=%0d tx=%b want 3 1", seq_state, tx_online);
        else n_pass++;
        rx_marker_seen = 1'b1;
        tick(1);
        rx_marker_seen = 1'b0;
        n_total++;
        if (seq_state !== 3'd4 || link_up !== 1'b1 || loss_cnt !== EXP_LOSS)
            $display("FAIL loss_reup: state=%0d up=%b loss=%0d want 4 1 %0d", seq_state, link_up, loss_cnt, EXP_LOSS);
        else n_pass++;
    endtask

    task automatic test_no_timeout();
        link_en = 1'b0;
        tick(1);
        n_total++;
        if (seq_state !== 3'd0 || loss_cnt !== EXP_LOSS || retry_cnt !== 4'd0)
            $display("FAIL idle_keep_loss: state=%0d loss=%0d retry=%0d want 0 %0d 0", seq_state, loss_cnt, retry_cnt, EXP_LOSS);
        else n_pass++;
        delay_x_value = 16'd0; delay_y_value = 16'd0; link_en = 1'b1;
        tick(3);
        delay_y_value = 16'd2;
        tick(10000);
        n_total++;
        if (seq_state !== 3'd3 || retry_cnt !== 4'd0 || tx_online !== 1'b1)
            $display("FAIL no_timeout: state=%0d retry=%0d tx=%b want 3 0 1", seq_state, retry_cnt, tx_online);
        else n_pass++;
    endtask

    task automatic test_reset_mid_settle();
        link_en = 1'b0;
        tick(1);
        delay_x_value = 16'd1000; link_en = 1'b1;
        tick(2);
        tick(200);
        n_total++;
        if (seq_state !== 3'd2) $display("FAIL mid_settle_state: state=%0d want 2", seq_state);
        else n_pass++;
        #2;
        rst_wr_n = 1'b0;
        #1;
        n_total++;
        if ({seq_state, tx_online, rx_online, link_up, link_err, retry_cnt, loss_cnt} !== 19'd0)
            $display("FAIL async_reset: state=%0d tx=%b rx=%b up=%b err=%b retry=%0d loss=%0d want all 0",
                     seq_state, tx_online, rx_online, link_up, link_err, retry_cnt, loss_cnt);
        else n_pass++;
        tick(2);
        rst_wr_n = 1'b1;
        link_en = 1'b0;
        tick(1);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_happy_path();
        test_retry_error();
        test_collision();
        test_align_loss();
        test_no_timeout();
        test_reset_mid_settle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
